// File: rtl/atm_session_timer_pkg.sv
// Shared constants for the ATM session timer and the session controller:
// state encoding and the default timeout/warning lengths.
package atm_session_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT_S = 30;
  localparam int DEFAULT_WARN_S    = 5;

  // Width needed to hold a seconds count from 0 up to and including max_s.
  function automatic int count_width(input int max_s);
    return (max_s < 1) ? 1 : $clog2(max_s + 1);
  endfunction

endpackage

// File: rtl/atm_session_timer_if.sv
// Control/status bundle between the session controller (master) and the
// session timer (slave).
interface atm_session_timer_if
  import atm_session_timer_pkg::*;
#(
  parameter int CW = count_width(DEFAULT_TIMEOUT_S)
) ();

  logic          start;
  logic          kick;
  logic          stop;
  logic          active;
  logic          warn;
  logic          expired;
  logic          timed_out;
  logic [CW-1:0] remaining;

  modport master (
    output start, kick, stop,
    input  active, warn, expired, timed_out, remaining
  );

  modport slave (
    input  start, kick, stop,
    output active, warn, expired, timed_out, remaining
  );

endinterface

// File: rtl/atm_session_timer_sec_tick.sv
// Brings the slow 1 Hz square wave into the clk domain and turns each of its
// rising edges into a single-cycle tick. Reusable by any second-based timer.
module sec_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic sec_in,
  output logic tick
);

  logic s1, s2, s3;

  // s1/s2 resolve metastability; s3 holds the previous synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sec_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

endmodule

// File: rtl/atm_session_timer.sv
// Customer-session countdown: start/kick/stop control, per-second decrement,
// near-end warning and a one-cycle expiry pulse for the session controller.
module atm_session_timer
  import atm_session_timer_pkg::*;
#(
  parameter int TIMEOUT_S = DEFAULT_TIMEOUT_S,
  parameter int WARN_S    = DEFAULT_WARN_S,
  parameter int CW        = count_width(TIMEOUT_S)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sec_in,
  atm_session_timer_if.slave  bus
);

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_S);
  localparam logic [CW-1:0] WARN_C    = CW'(WARN_S);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  logic          tick;
  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          expired_q, expired_d;

  sec_tick_sync u_sec_tick_sync (
    .clk    (clk),
    .rst    (rst),
    .sec_in (sec_in),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      expired_q <= expired_d;
    end
  end

  // Priority stop > start > kick > tick. The remaining==1 case is handled on
  // its own so the decrement can never wrap below zero.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    expired_d = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (bus.start) begin
      state_d = RUN;
      rem_d   = TIMEOUT_C;
    end else if (state_q == RUN) begin
      if (bus.kick) begin
        rem_d = TIMEOUT_C;
      end else if (tick) begin
        if (rem_q > ONE_C) begin
          rem_d = rem_q - ONE_C;
        end else begin
          state_d   = EXPIRED;
          rem_d     = '0;
          expired_d = 1'b1;
        end
      end
    end
  end

  assign bus.active    = (state_q == RUN);
  assign bus.warn      = (state_q == RUN) && (rem_q <= WARN_C);
  assign bus.timed_out = (state_q == EXPIRED);
  assign bus.expired   = expired_q;
  assign bus.remaining = rem_q;

endmodule

// File: doc/atm_session_timer.md
# atm_session_timer

Countdown timer that consumes the free-running 1 Hz square wave produced by the seconds divider and enforces the ATM customer-session timeout. It synchronizes the slow level into the system clock domain and detects its rising edges as one-cycle second ticks. It then runs a start/kick/stop countdown that raises a warning near the end and flags expiry to the session controller.

## Interface
Parameters:
- TIMEOUT_S, default 30: session length in seconds; must be ≥ 1.
- WARN_S, default 5: warning threshold in seconds; must be < TIMEOUT_S.
- CW, default $clog2(TIMEOUT_S+1): width of the remaining-seconds count.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- sec_in  input  1  1 Hz square wave from the seconds divider; asynchronous to clk.
- start  input  1  begin or restart a session (one-cycle pulse).
- kick  input  1  customer activity; reloads the countdown while running.
- stop  input  1  end the session; return to idle.
- active  output  1  high in RUN.
- warn  output  1  high in RUN while remaining ≤ WARN_S.
- expired  output  1  one-cycle pulse on the RUN→EXPIRED transition.
- timed_out  output  1  level, high in EXPIRED.
- remaining  output  CW  seconds left; 0 outside RUN.

## Operation
- Tick detection:
  - sec_in passes through a 2-flop synchronizer (s1, s2), then a history flop s3.
  - tick = s2 & ~s3 (combinational, internal).
- States are IDLE, RUN and EXPIRED. Reset enters IDLE with remaining = 0.
- Per-cycle priority is stop > start > kick > tick:
  - stop (any state): go to IDLE, remaining ← 0.
  - start (any state): go to RUN, remaining ← TIMEOUT_S. In RUN this acts as a reload.
  - kick in RUN: remaining ← TIMEOUT_S. kick is ignored in IDLE and EXPIRED.
  - tick in RUN:
    - If remaining > 1: remaining ← remaining − 1.
    - If remaining == 1: remaining ← 0, go to EXPIRED, expired = 1 for exactly that cycle.
  - tick in IDLE or EXPIRED is ignored.
- EXPIRED holds timed_out high until start or stop.
- Output decoding:
  - active, warn and timed_out decode combinationally from the state and remaining registers. There is no glitch requirement beyond being registered-source.
  - expired is a registered pulse.
- Arithmetic:
  - The decrement is unsigned in CW bits and never underflows, because the remaining == 1 case is handled explicitly.
  - Reload truncates nothing, since CW covers TIMEOUT_S.

## Timing
- Reset values:
  - s1, s2, s3 = 0
  - state = IDLE
  - remaining = 0
  - active, warn, expired, timed_out = 0
- Tick latency: a sec_in rise sampled at clk edge N makes tick high after edge N+1. remaining updates at edge N+2.
- Control latency: start, kick and stop act at the first clk edge where they are sampled high. Outputs reflect the change in the following cycle.
- If sec_in is already high at reset release, s2 rises and produces one tick. That tick is harmless: state is IDLE, so it is ignored.
- Simultaneous events:
  - kick and tick in the same cycle: reload wins, with no decrement.
  - start and tick in EXPIRED: go to RUN with TIMEOUT_S.
  - stop and anything else: IDLE.
- If rst asserts mid-session, all state clears immediately (asynchronous). No expired pulse is produced.
- sec_in high and low phases each span ≫ 3 clk cycles, so exactly one tick is produced per sec_in period.

## Structure
- Shared constants header/package:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2
  - default TIMEOUT_S and WARN_S, shared with the session controller
- Sub-module sec_tick_sync contains s1, s2, s3 and the tick edge detect. Its ports are clk, rst, sec_in and tick, and it is reusable by other second-based timers.
- The top level contains the FSM, the remaining counter and output decode.

## Test plan
Bench settings: TIMEOUT_S = 4, WARN_S = 2, sec_in period 40 clk cycles.

- Reset with sec_in high, no start → state IDLE, all outputs 0 throughout, remaining = 0.
- start, then no activity → remaining 4, 3, 2 (warn rises), 1, then expired pulses for 1 cycle. Each step lands 2 cycles after a sec_in rise. timed_out then stays high, with remaining = 0.
- start, two ticks, then kick → remaining returns to 4, warn drops, and expiry is delayed by two further ticks.
- kick asserted in the same cycle as a tick with remaining = 2 → remaining = 4, not 1 or 3.
- In EXPIRED: kick → no change. start coincident with a tick → RUN with remaining 4 and timed_out cleared.
- rst asserted mid-RUN with remaining = 3 → outputs clear asynchronously, expired is never pulsed, and state is IDLE after release.
